gpu_task_sched: RTL

Parametrised task scheduler between program memory and the core array. It holds the program image, walks it task by task, and streams each task to the cores over one valid/ready message bus: core mask, then r0 init vector, then `if_num` instruction frames. Before each task it enforces the task's fence (none/acquire/release) and core-collision rules against live core status. It replaces the fixed 16-core, fixed-layout scheduler and adds a handshake, an end-of-program marker and an overflow error.

---
 rtl/gpu_task_sched.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/gpu_task_sched.sv
// Task scheduler: walks the program image and streams mask, r0 and instruction frames to the cores.
// Optional performance counters are enabled with the GPU_SCHED_PERF_EN macro.
`timescale 1ns/1ps
module gpu_task_sched #(
  parameter int DATA_DEPTH  = 1024,
  parameter int INSTR_SIZE  = 16,
  parameter int CORE_NUM    = 16,
  parameter int FRAME_WORDS = 16,
  parameter int IFNUM_W     = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          prog_loading,
  input  logic                          prog_we,
  input  logic [$clog2(DATA_DEPTH)-1:0] prog_addr,
  input  logic [INSTR_SIZE-1:0]         prog_data,
  input  logic                          start,
  input  logic [CORE_NUM-1:0]           core_ready,
  input  logic                          mess_ready,
  output logic                          mess_valid,
  output logic [INSTR_SIZE-1:0]         mess_to_core,
  output logic                          core_mask_loading,
  output logic                          r0_loading,
  output logic                          if_loading,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [31:0]                   stall_cnt,
  output logic [15:0]                   task_cnt
);
  localparam int AW = $clog2(DATA_DEPTH);
  localparam int RW = IFNUM_W + $clog2(FRAME_WORDS) + 1;
  localparam logic [1:0] F_ACQ = 2'b01;
  localparam logic [1:0] F_REL = 2'b10;
  localparam logic [1:0] F_END = 2'b11;

  // state | meaning
  // IDLE  | no run, waiting for start
  // HDR   | latch task header words 0..2
  // WAIT  | hold until fence/collision gate opens
  // MASK  | core mask word on the bus
  // R0    | r0 init vector on the bus
  // INSTR | instruction frame words on the bus
  // DONE  | program end or overflow reached
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_WAIT, S_MASK, S_R0, S_INSTR, S_DONE} state_t;

  state_t                state;
  logic [INSTR_SIZE-1:0] mem [DATA_DEPTH];
  logic [AW:0]           tp;
  logic [AW:0]           ip;
  logic [RW-1:0]         rem;
  logic [IFNUM_W-1:0]    if_num_q;
  logic [1:0]            fence_q;
  logic [INSTR_SIZE-1:0] word1_q;
  logic [INSTR_SIZE-1:0] r0_q;
  logic [CORE_NUM-1:0]   prev_mask;

  logic [AW-1:0]         tpa;
  logic [CORE_NUM-1:0]   busy_m;
  logic [CORE_NUM-1:0]   mask_q;
  logic                  gate;
  logic                  start_ok;
  logic [AW:0]           ia;
  logic                  ia_ok;
  logic                  tp_ovf;
  logic                  more;
  logic [RW-1:0]         total;

  always_ff @(posedge clk) begin
    if (prog_loading && prog_we) mem[prog_addr] <= prog_data;
  end

  assign tpa      = tp[AW-1:0];
  assign busy_m   = ~core_ready;
  assign mask_q   = word1_q[CORE_NUM-1:0];
  assign start_ok = start && !prog_loading && (state == S_IDLE || state == S_DONE);
  // ia doubles as the next task pointer once the last word of a task has transferred
  assign ia       = (state == S_R0) ? tp + (AW+1)'(4) : ip + (AW+1)'(1);
  assign ia_ok    = ia < (AW+1)'(DATA_DEPTH);
  assign tp_ovf   = ({1'b0, ia} + (AW+2)'(4)) > (AW+2)'(DATA_DEPTH);
  assign more     = (state == S_R0) ? (if_num_q != '0) : (rem != RW'(1));
  assign total    = RW'(if_num_q) * RW'(FRAME_WORDS);

  always_comb begin
    gate = ((mask_q & busy_m) == '0);
    if (fence_q == F_ACQ && (prev_mask & busy_m) != '0) gate = 1'b0;
    if (fence_q == F_REL && busy_m != '0) gate = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      tp                <= '0;
      ip                <= '0;
      rem               <= '0;
      if_num_q          <= '0;
      fence_q           <= '0;
      word1_q           <= '0;
      r0_q              <= '0;
      prev_mask         <= '0;
      mess_valid        <= 1'b0;
      mess_to_core      <= '0;
      core_mask_loading <= 1'b0;
      r0_loading        <= 1'b0;
      if_loading        <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
    end else if (prog_loading) begin
      state             <= S_IDLE;
      mess_valid        <= 1'b0;
      core_mask_loading <= 1'b0;
      r0_loading        <= 1'b0;
      if_loading        <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state <= S_HDR;
            tp    <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
          end
        end
        S_HDR: begin
          if_num_q <= mem[tpa][IFNUM_W-1:0];
          fence_q  <= mem[tpa][7:6];
          word1_q  <= mem[tpa + AW'(1)];
          r0_q     <= mem[tpa + AW'(2)];
          if (mem[tpa][7:6] == F_END) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (gate) begin
            state             <= S_MASK;
            mess_valid        <= 1'b1;
            mess_to_core      <= word1_q;
            core_mask_loading <= 1'b1;
          end
        end
        S_MASK: begin
          if (mess_ready) begin
            state             <= S_R0;
            mess_to_core      <= r0_q;
            core_mask_loading <= 1'b0;
            r0_loading        <= 1'b1;
            prev_mask         <= mask_q;
          end
        end
        S_R0, S_INSTR: begin
          if (mess_ready) begin
            r0_loading <= 1'b0;
            if (more && ia_ok) begin
              state        <= S_INSTR;
              mess_to_core <= mem[ia[AW-1:0]];
              if_loading   <= 1'b1;
              ip           <= ia;
              rem          <= (state == S_R0) ? total : rem - RW'(1);
            end else begin
              mess_valid <= 1'b0;
              if_loading <= 1'b0;
              if (more || tp_ovf) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                err   <= 1'b1;
              end else begin
                state <= S_HDR;
                tp    <= ia;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GPU_SCHED_PERF_EN
  logic [31:0] stall_q;
  logic [15:0] task_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      task_q  <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
      task_q  <= '0;
    end else if (!prog_loading) begin
      if (state == S_WAIT && !gate && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (state == S_MASK && mess_ready) task_q <= task_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign task_cnt  = task_q;
`else
  assign stall_cnt = '0;
  assign task_cnt  = '0;
`endif

endmodule
